// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ifetch_state_t;

    // MOV r0, r0: what IF/ID sees whenever no instruction is consumed.
    localparam logic [31:0] IFETCH_NOP = 32'hE1A00000;

endpackage

// File: rtl/ifetch_line_buf.sv
// One-entry fetch line buffer {addr, instr, valid}; used only when IFETCH_BUF_EN is defined.
module ifetch_line_buf
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic              valid_r;

    // Entry storage, replaced on every accepted memory delivery.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r  <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
        end else if (wr_en) begin
            addr_r  <= wr_addr;
            data_r  <= wr_data;
            valid_r <= 1'b1;
        end
    end

    assign hit      = valid_r && (lookup_addr == addr_r);
    assign hit_data = data_r;

endmodule

// File: rtl/ifetch_ctrl.sv
// IF-stage fetch controller: PC -> req/ack memory -> IF/ID, driving the PC freeze.
// Optional one-entry line buffer enabled by defining IFETCH_BUF_EN.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              hazard_freeze,
    input  logic              branch_taken,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              freeze_out,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid
);

    ifetch_state_t     state_r;
    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] hold_r;
    logic              drop_pend_r;

    logic              accept_s;
    logic              valid_s;
    logic [DATA_W-1:0] data_s;
    logic              buf_hit_s;
    logic [DATA_W-1:0] buf_data_s;

    // Ack whose data survives (no pending or same-cycle branch flush).
    assign accept_s = (state_r == S_WAIT) && mem_ack && !drop_pend_r && !branch_taken;

`ifdef IFETCH_BUF_EN
    ifetch_line_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_line_buf (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (pc_in),
        .hit         (buf_hit_s),
        .hit_data    (buf_data_s),
        .wr_en       (accept_s),
        .wr_addr     (mem_addr_r),
        .wr_data     (mem_rdata)
    );
`else
    assign buf_hit_s  = 1'b0;
    assign buf_data_s = '0;
`endif

    // Select what IF/ID consumes this cycle; memory data passes straight through.
    always_comb begin
        valid_s = 1'b0;
        data_s  = hold_r;
        case (state_r)
            S_IDLE: begin
                if (!branch_taken && buf_hit_s && !hazard_freeze) begin
                    valid_s = 1'b1;
                    data_s  = buf_data_s;
                end else begin
                    valid_s = 1'b0;
                end
            end
            S_WAIT: begin
                if (accept_s && !hazard_freeze) begin
                    valid_s = 1'b1;
                    data_s  = mem_rdata;
                end else begin
                    valid_s = 1'b0;
                end
            end
            S_HOLD: begin
                if (!branch_taken && !hazard_freeze) begin
                    valid_s = 1'b1;
                end else begin
                    valid_s = 1'b0;
                end
            end
            default: begin
                valid_s = 1'b0;
            end
        endcase
    end

    // Outputs are forced to their idle values while reset is asserted.
    assign instr_valid = valid_s && !rst;
    assign instr_out   = instr_valid ? data_s : DATA_W'(IFETCH_NOP);
    assign freeze_out  = rst || !(valid_s || branch_taken);
    assign mem_req     = mem_req_r;
    assign mem_addr    = mem_addr_r;

    // Fetch FSM with registered request, address, hold data and flush marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= '0;
            hold_r      <= '0;
            drop_pend_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!branch_taken && !buf_hit_s) begin
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= pc_in;
                        state_r    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        mem_req_r   <= 1'b0;
                        drop_pend_r <= 1'b0;
                        if (accept_s && hazard_freeze) begin
                            hold_r  <= mem_rdata;
                            state_r <= S_HOLD;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end else if (branch_taken) begin
                        // The request cannot be aborted, so its data is dropped later.
                        drop_pend_r <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (branch_taken || !hazard_freeze) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed self-checking bench for ifetch_ctrl; covers the IFETCH_BUF_EN build when defined.
module tb_ifetch_ctrl;

    localparam logic [31:0] NOP = 32'hE1A00000;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        hazard_freeze;
    logic        branch_taken;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        freeze_out;
    logic [31:0] instr_out;
    logic        instr_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    ifetch_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_in         (pc_in),
        .hazard_freeze (hazard_freeze),
        .branch_taken  (branch_taken),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .freeze_out    (freeze_out),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; pc_in = 32'h0000_0100; hazard_freeze = 1'b0; branch_taken = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'h0000_0000;
        mid();
        chk1("rst_req", mem_req, 1'b0);
        chk32("rst_addr", mem_addr, 32'h0);
        chk1("rst_valid", instr_valid, 1'b0);
        chk1("rst_freeze", freeze_out, 1'b1);
        chk32("rst_instr", instr_out, NOP);
        tick();
        rst = 1'b0;

        // Fetch 0x100 with ack on the third WAIT cycle: 4 cycles total
        mid();
        chk1("a_req", mem_req, 1'b0);
        chk1("a_freeze", freeze_out, 1'b1);
        tick();
        mid();
        chk1("b_req", mem_req, 1'b1);
        chk32("b_addr", mem_addr, 32'h100);
        chk1("b_valid", instr_valid, 1'b0);
        tick();
        mid();
        chk1("c_req_held", mem_req, 1'b1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hE3A01005;
        mid();
        chk1("d_valid", instr_valid, 1'b1);
        chk32("d_instr", instr_out, 32'hE3A01005);
        chk1("d_freeze", freeze_out, 1'b0);
        tick();
        mem_ack = 1'b0; mem_rdata = 32'hDEADBEEF; pc_in = 32'h104;
        mid();
        chk1("e_req_low", mem_req, 1'b0);
        chk1("e_valid", instr_valid, 1'b0);
        chk32("e_instr_nop", instr_out, NOP);
        chk1("e_freeze", freeze_out, 1'b1);
        tick();

        // Immediate ack under hazard freeze -> hold until freeze drops
        mem_ack = 1'b1; mem_rdata = 32'hE3A01005; hazard_freeze = 1'b1;
        mid();
        chk1("f_req", mem_req, 1'b1);
        chk32("f_addr", mem_addr, 32'h104);
        chk1("f_valid", instr_valid, 1'b0);
        chk1("f_freeze", freeze_out, 1'b1);
        chk32("f_instr_nop", instr_out, NOP);
        tick();
        mem_ack = 1'b0; mem_rdata = 32'hDEADBEEF;
        mid();
        chk1("g_hold_valid", instr_valid, 1'b0);
        chk1("g_hold_freeze", freeze_out, 1'b1);
        chk1("g_req", mem_req, 1'b0);
        tick();
        hazard_freeze = 1'b0;
        mid();
        chk1("h_valid", instr_valid, 1'b1);
        chk32("h_instr", instr_out, 32'hE3A01005);
        chk1("h_freeze", freeze_out, 1'b0);
        tick();
        pc_in = 32'h108;
        mid();
        chk1("i_valid", instr_valid, 1'b0);
        tick();

        // Branch mid-WAIT: later ack dropped, next fetch from 0x200
        branch_taken = 1'b1;
        mid();
        chk32("j_addr", mem_addr, 32'h108);
        chk1("j_freeze_br", freeze_out, 1'b0);
        chk1("j_valid", instr_valid, 1'b0);
        tick();
        branch_taken = 1'b0; pc_in = 32'h200;
        mid();
        chk1("k_freeze", freeze_out, 1'b1);
        chk1("k_req_held", mem_req, 1'b1);
        chk32("k_addr_stable", mem_addr, 32'h108);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        mid();
        chk1("l_drop_valid", instr_valid, 1'b0);
        chk32("l_drop_instr", instr_out, NOP);
        chk1("l_drop_freeze", freeze_out, 1'b1);
        tick();
        mem_ack = 1'b0;
        mid();
        chk1("m_req_low", mem_req, 1'b0);
        tick();

        // Ack and branch in the same cycle
        mem_ack = 1'b1; branch_taken = 1'b1; mem_rdata = 32'h2222_2222;
        mid();
        chk1("n_req", mem_req, 1'b1);
        chk32("n_addr", mem_addr, 32'h200);
        chk1("n_valid", instr_valid, 1'b0);
        chk1("n_freeze", freeze_out, 1'b0);
        chk32("n_instr", instr_out, NOP);
        tick();
        mem_ack = 1'b0; pc_in = 32'h300;

        // Branch while idle: no request issued that cycle
        mid();
        chk1("o_req_low", mem_req, 1'b0);
        chk1("o_freeze_br", freeze_out, 1'b0);
        tick();
        branch_taken = 1'b0;
        mid();
        chk1("o2_no_req", mem_req, 1'b0);
        tick();

        // Minimum 2-cycle fetch; drop_pend must be clear
        mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
        mid();
        chk1("p_req", mem_req, 1'b1);
        chk32("p_addr", mem_addr, 32'h300);
        chk1("p_valid", instr_valid, 1'b1);
        chk32("p_instr", instr_out, 32'h3333_3333);
        tick();
        mem_ack = 1'b0; pc_in = 32'h304;
        tick();

        // Reset asserted mid-WAIT
        mid();
        chk1("r_req", mem_req, 1'b1);
        chk32("r_addr", mem_addr, 32'h304);
        rst = 1'b1;
        #1;
        chk1("r_rst_req", mem_req, 1'b0);
        chk1("r_rst_freeze", freeze_out, 1'b1);
        chk32("r_rst_instr", instr_out, NOP);
        chk32("r_rst_addr", mem_addr, 32'h0);
        tick();
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h4444_4444;
        mid();
        chk1("s_stray_valid", instr_valid, 1'b0);
        chk32("s_stray_instr", instr_out, NOP);
        chk1("s_stray_freeze", freeze_out, 1'b1);
        tick();
        mem_ack = 1'b0;
        mid();
        chk1("t_req", mem_req, 1'b1);
        chk1("t_valid", instr_valid, 1'b0);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        mid();
        chk1("u_valid", instr_valid, 1'b1);
        chk32("u_instr", instr_out, 32'h5555_5555);
        tick();
        mem_ack = 1'b0; pc_in = 32'h100;
        tick();

        // Refetch of 0x100 after delivery
        mem_ack = 1'b1; mem_rdata = 32'hE3A01005;
        mid();
        chk32("w_addr", mem_addr, 32'h100);
        chk1("w_valid", instr_valid, 1'b1);
        tick();
        mem_ack = 1'b0; mem_rdata = 32'hDEADBEEF;
        mid();
`ifdef IFETCH_BUF_EN
        chk1("x_buf_valid", instr_valid, 1'b1);
        chk32("x_buf_instr", instr_out, 32'hE3A01005);
        chk1("x_buf_freeze", freeze_out, 1'b0);
        tick();
        mid();
        chk1("y_buf_no_req", mem_req, 1'b0);
`else
        chk1("x_valid", instr_valid, 1'b0);
        chk1("x_freeze", freeze_out, 1'b1);
        tick();
        mid();
        chk1("y_req", mem_req, 1'b1);
        chk32("y_addr", mem_addr, 32'h100);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
